// File: rtl/quad_decoder.sv
// rtl/quad_decoder.sv - x4 quadrature decoder with sync, optional glitch filter and loadable position count
// Phase pins are synchronized, filtered, decoded into up/down steps that drive a wrapping position counter.
module quad_decoder #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             clr_err,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             step,
  output logic             err
);

  logic [SYNC_STAGES-1:0] a_sync;
  logic [SYNC_STAGES-1:0] b_sync;
  logic [SYNC_STAGES-1:0] sync_vld;
  logic [1:0]             sync_pair;
  logic                   sync_ok;
  logic                   acc_vld;
  logic [1:0]             acc_pair;

  // sync_vld tracks when the chain holds real pin samples rather than reset zeros,
  // so encoders resting at 11 through reset do not look like a 00->11 jump.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sync   <= '0;
      b_sync   <= '0;
      sync_vld <= '0;
    end else begin
      a_sync   <= {a_sync[SYNC_STAGES-2:0], a_in};
      b_sync   <= {b_sync[SYNC_STAGES-2:0], b_in};
      sync_vld <= {sync_vld[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_pair = {a_sync[SYNC_STAGES-1], b_sync[SYNC_STAGES-1]};
  assign sync_ok   = sync_vld[SYNC_STAGES-1];

  generate
    if (FILT_CYCLES == 0) begin : g_no_filt
      assign acc_vld  = sync_ok;
      assign acc_pair = sync_pair;
    end else begin : g_filt
      logic [1:0] cand;
      logic [3:0] filt_cnt;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cand     <= 2'b00;
          filt_cnt <= 4'd0;
        end else if (sync_ok) begin
          if (sync_pair != cand) begin
            cand     <= sync_pair;
            filt_cnt <= 4'd0;
          end else if (filt_cnt != 4'(FILT_CYCLES)) begin
            filt_cnt <= filt_cnt + 4'd1;
          end
        end
      end

      assign acc_vld  = sync_ok && (filt_cnt == 4'(FILT_CYCLES));
      assign acc_pair = cand;
    end
  endgenerate

  logic [1:0] p;
  logic       init;
  logic [1:0] s_idx;
  logic [1:0] p_idx;
  logic [1:0] delta;
  logic       fwd;
  logic       rev;
  logic       illegal;

  // Gray position: 00->0, 10->1, 11->2, 01->3; forward is +1 mod 4, opposite corner is +2.
  assign s_idx = {acc_pair[0], acc_pair[1] ^ acc_pair[0]};
  assign p_idx = {p[0], p[1] ^ p[0]};
  assign delta = s_idx - p_idx;

  always_comb begin
    fwd     = 1'b0;
    rev     = 1'b0;
    illegal = 1'b0;
    if (acc_vld && !init) begin
      fwd     = (delta == 2'd1);
      rev     = (delta == 2'd3);
      illegal = (delta == 2'd2);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p     <= 2'b00;
      init  <= 1'b1;
      count <= '0;
      dir   <= 1'b0;
      step  <= 1'b0;
      err   <= 1'b0;
    end else begin
      if (acc_vld) begin
        p    <= acc_pair;
        init <= 1'b0;
      end
      step <= fwd | rev;
      if (fwd | rev)
        dir <= fwd;
      if (load)
        count <= data;
      else if (fwd)
        count <= count + WIDTH'(1);
      else if (rev)
        count <= count - WIDTH'(1);
      err <= illegal | (err & ~clr_err);
    end
  end

endmodule

// File: doc/quad_decoder.md
# quad_decoder

Quadrature-encoder front end that turns two phase inputs (A/B) into signed position steps. It maintains a wrap-around position count with parallel load. Raw pins are synchronized and optionally glitch-filtered, then decoded at x4 resolution (one count per phase edge). It also reports the last direction, a per-step pulse, and a sticky illegal-transition flag. It sits between the encoder pins and the counter/position logic, acting as the producer of the step and up/down controls that a load-able up/down counter consumes.

## Interface
- WIDTH, 8: width of data and count.
- SYNC_STAGES, 2: synchronizer flops per phase input; legal range 2..4.
- FILT_CYCLES, 0: consecutive stable edges required before a new A/B pair is accepted; 0 bypasses the filter; legal range 0..15.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- a_in  input  1  encoder phase A; asynchronous to clk.
- b_in  input  1  encoder phase B; asynchronous to clk.
- load  input  1  synchronous load of data into count.
- data  input  WIDTH  load value.
- clr_err  input  1  synchronous clear of err.
- count  output  WIDTH  position; registered.
- dir  output  1  last valid step direction; 1 = up, 0 = down.
- step  output  1  one-cycle pulse per valid phase transition.
- err  output  1  sticky illegal-transition flag.

## Operation
- Synchronizer: A and B each pass through SYNC_STAGES flops. All sync flops reset to 0.
- Filter, FILT_CYCLES=N>0:
  - Candidate register cand[1:0] plus a stability counter.
  - When the synchronized pair differs from cand: cand loads the new pair and the counter clears to 0.
  - Otherwise the counter increments, saturating at N.
  - The pair is accepted when counter == N.
  - With N=0, the synchronized pair is accepted directly.
- Decoder: compares the accepted pair s={A,B} with the previous pair p.
  - Forward (+1) sequence: 00→10→11→01→00.
  - Reverse (−1) sequence: 00→01→11→10→00.
  - s==p: no action.
  - Both bits changed (00↔11, 10↔01): illegal. err sets, count is unchanged, no step pulse, dir is unchanged.
  - p updates to s on every accepted sample, legal or illegal.
- Init: an init flag is set by reset. The first accepted sample after reset loads p without counting, stepping, or flagging, then clears the flag. This means encoder pins resting at 11 at reset produce no false error.
- Count update priority, highest first:
  - load: count ← data.
  - Valid step: count ← count ± 1, modulo 2^WIDTH.
  - Otherwise hold.
- A step that coincides with load is discarded for count. step still pulses and dir still updates.
- Wrap-around: count of all-ones plus +1 gives 0; count of 0 plus −1 gives all-ones. No flag is raised.
- err: set by an illegal transition, cleared by clr_err. When both occur in the same cycle, set wins and err=1.

## Timing
- Reset values: count=0, dir=0, step=0, err=0, p=00, init=1, sync flops=0, cand=00, filter counter=0.
- Reset takes effect asynchronously. Deassertion is assumed synchronized externally. Reset mid-rotation discards all partial state; the next accepted sample re-initializes p.
- Latency is measured from an a_in/b_in change to count/step/dir/err update, counted in rising edges including the capturing edge:
  - FILT_CYCLES=0: SYNC_STAGES+1 edges.
  - FILT_CYCLES=N>0: SYNC_STAGES+N+2 edges.
- step is high for exactly one cycle, in the same cycle count changes.
- load and clr_err take effect on the next rising edge (1-cycle latency).
- Throughput: one step per cycle is possible when phase inputs change no faster than the filter and synchronizer latency.
- Any glitch shorter than N+1 edges at the synchronizer output is rejected with no step.

## Test plan
- Reset then forward rotation:
  - Stimulus: rst_n low, then high; A/B=00; drive 00→10→11→01→00, holding each pair 4 cycles; FILT_CYCLES=0.
  - Required: count 0→4, 4 step pulses, dir=1, err=0, each update SYNC_STAGES+1 edges after the input change.
- Reverse and wrap:
  - Stimulus: load data=8'h01, then 3 reverse steps.
  - Required: count 01→00→FF→FE, dir=0.
  - Then 2 forward steps. Required: count FF→00.
- Illegal transition:
  - Stimulus: from 00 jump to 11.
  - Required: err=1, count unchanged, no step.
  - Then pulse clr_err in the same cycle as a second 10→01 jump. Required: err stays 1.
  - Then clr_err alone. Required: err=0.
- Load collision:
  - Stimulus: assert load with data=8'h80 on the edge where a forward step applies.
  - Required: count=80, step=1, dir=1.
- Filter (FILT_CYCLES=3):
  - Stimulus: 2-cycle glitch 00→10→00 on A.
  - Required: no step, count unchanged.
  - Stimulus: a held 00→10 change.
  - Required: count+1 exactly SYNC_STAGES+5 edges after the change.
- Power-up at 11 and reset mid-operation:
  - Stimulus: pins at 11 through reset release, then 11→01.
  - Required: no err, count=1. Wait, 11→01 is forward so count=0x01, dir=1.
  - Stimulus: assert rst_n low mid-sequence.
  - Required: all outputs return to reset values immediately.
